// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch with one outstanding cache request, DEPTH-entry {pc, inst} FIFO, flush/redirect.
// Optional same-cycle response-to-decode bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  inst_req,
    output logic [DATA_WIDTH-1:0] inst_addr,
    input  logic                  inst_valid,
    input  logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [DATA_WIDTH-1:0] out_pc,
    input  logic                  out_ready
);
    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_pc   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_inst [DEPTH];

    logic [AW:0]           wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count_n;
    logic [DATA_WIDTH-1:0] fetch_pc, fetch_pc_n, addr_q, addr_n;
    logic                  pending, pending_n, drop, drop_n;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_inst_q, out_pc_q;
    logic                  resp, take, pop, push, head_new, bypass_take;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign inst_req       = pending;
    assign inst_addr      = addr_q;

    always_comb begin
        resp       = pending & inst_valid;
        take       = resp & ~drop & ~redirect;
        pop        = out_valid_q & out_ready;
        push       = take & ~bypass_take;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        fetch_pc_n = fetch_pc;
        drop_n     = drop;
        pending_n  = pending;
        addr_n     = addr_q;
        if (redirect) begin
            wr_ptr_n   = '0;
            rd_ptr_n   = '0;
            fetch_pc_n = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            pending_n  = 1'b1;
            // An unanswered request keeps its address; its response is thrown away later.
            if (pending & ~inst_valid) begin
                drop_n = 1'b1;
            end else begin
                drop_n = 1'b0;
                addr_n = fetch_pc_n;
            end
        end else begin
            wr_ptr_n = wr_ptr + (AW+1)'(push);
            rd_ptr_n = rd_ptr + (AW+1)'(pop);
            if (take) fetch_pc_n = fetch_pc + DATA_WIDTH'(4);
            if (resp) drop_n = 1'b0;
            if (!(pending & ~inst_valid)) begin
                pending_n = ((wr_ptr_n - rd_ptr_n) < FULL);
                addr_n    = fetch_pc_n;
            end
        end
        count_n  = wr_ptr_n - rd_ptr_n;
        // The entry written this cycle becomes the head when everything older has drained.
        head_new = push & (rd_ptr_n == wr_ptr);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr[AW-1:0]]   <= fetch_pc;
            mem_inst[wr_ptr[AW-1:0]] <= inst_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fetch_pc    <= RESET_PC;
            addr_q      <= RESET_PC;
            pending     <= 1'b0;
            drop        <= 1'b0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            fetch_pc    <= fetch_pc_n;
            addr_q      <= addr_n;
            pending     <= pending_n;
            drop        <= drop_n;
            out_valid_q <= (count_n != '0);
            if (head_new) begin
                out_inst_q <= inst_data;
                out_pc_q   <= fetch_pc;
            end else if (count_n != '0) begin
                out_inst_q <= mem_inst[rd_ptr_n[AW-1:0]];
                out_pc_q   <= mem_pc[rd_ptr_n[AW-1:0]];
            end
        end
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_hit;
    // A response into an empty queue is shown to decode in the same cycle.
    assign bypass_hit  = take & (wr_ptr == rd_ptr);
    assign bypass_take = bypass_hit & out_ready;
    assign out_valid   = out_valid_q | bypass_hit;
    assign out_inst    = bypass_hit ? inst_data : out_inst_q;
    assign out_pc      = bypass_hit ? fetch_pc : out_pc_q;
`else
    assign bypass_take = 1'b0;
    assign out_valid   = out_valid_q;
    assign out_inst    = out_inst_q;
    assign out_pc      = out_pc_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_valid = 1'b0;
    logic [31:0] inst_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_valid(inst_valid), .inst_data(inst_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic        m_req, m_drop;
    logic [31:0] m_addr, m_fpc;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        q.delete();
        m_req  = 1'b0;
        m_drop = 1'b0;
        m_addr = RESET_PC;
        m_fpc  = RESET_PC;
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model across the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r,
                        input logic [31:0] rp, input logic rdy);
        logic byp, resp, pop;
        ent_t e;
        inst_valid = v; inst_data = d; redirect = r; redirect_pc = rp; out_ready = rdy;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = rst && m_req && v && !m_drop && !r && (q.size() == 0);
`endif
        check_eq("inst_req", inst_req, m_req);
        if (m_req || !rst) check_eq("inst_addr", inst_addr, m_addr);
        check_eq("out_valid", out_valid, (q.size() > 0) || byp);
        if (byp) begin
            check_eq("out_inst", out_inst, d);
            check_eq("out_pc", out_pc, m_addr);
        end else if (q.size() > 0) begin
            check_eq("out_inst", out_inst, q[0].inst);
            check_eq("out_pc", out_pc, q[0].pc);
        end else if (!rst) begin
            check_eq("out_inst_rst", out_inst, 32'h0);
            check_eq("out_pc_rst", out_pc, 32'h0);
        end
        @(posedge clk);
        if (rst) begin
            resp = m_req && v;
            pop  = (q.size() > 0) && rdy;
            if (r) begin
                q.delete();
                m_fpc = rp & ~32'h3;
                if (m_req && !v) m_drop = 1'b1;
                else begin
                    m_drop = 1'b0;
                    m_addr = m_fpc;
                end
                m_req = 1'b1;
            end else begin
                if (pop) void'(q.pop_front());
                if (resp) begin
                    if (m_drop) m_drop = 1'b0;
                    else begin
                        e.pc = m_fpc; e.inst = d;
                        if (!(byp && rdy)) q.push_back(e);
                        m_fpc = m_fpc + 32'd4;
                    end
                end
                if (!(m_req && !resp)) begin
                    m_req  = (q.size() < DEPTH);
                    m_addr = m_fpc;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    task automatic rand_step();
        step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        logic        v, r, rdy;
        logic [31:0] rp;
        model_reset();
        @(negedge clk);
        // Reset held with random inputs: outputs stay at reset values
        for (int i = 0; i < 4; i++) rand_step();
        rst = 1'b1;
        idle(1'b0);
        check_eq("first_req", inst_req, 1'b1);
        check_eq("first_addr", inst_addr, RESET_PC);

        // Fill: cache answers one cycle after each request, decode stalled
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            check_eq("fill_req", inst_req, 1'b1);
            check_eq("fill_addr", inst_addr, 32'(4 * k));
            step(1'b1, 32'hA0 + 32'(k), 1'b0, 32'h0, 1'b0);
        end
        check_eq("full_req", inst_req, 1'b0);
        idle(1'b0);
        check_eq("full_req_hold", inst_req, 1'b0);

        // Drain in order; the first pop re-opens fetch at 0x10
        for (int k = 0; k < 4; k++) begin
            check_eq("drain_valid", out_valid, 1'b1);
            check_eq("drain_pc", out_pc, 32'(4 * k));
            check_eq("drain_inst", out_inst, 32'hA0 + 32'(k));
            if (k == 1) begin
                check_eq("refill_req", inst_req, 1'b1);
                check_eq("refill_addr", inst_addr, 32'h10);
            end
            idle(1'b1);
        end
        check_eq("drained_valid", out_valid, 1'b0);

        // Redirect while the request to 0x10 is outstanding
        step(1'b0, 32'h0, 1'b1, 32'h103, 1'b0);
        check_eq("redir_hold_addr", inst_addr, 32'h10);
        idle(1'b0);
        check_eq("redir_hold_addr2", inst_addr, 32'h10);
        step(1'b1, 32'hDEAD, 1'b0, 32'h0, 1'b0);
        check_eq("redir_new_addr", inst_addr, 32'h100);
        check_eq("redir_dropped", out_valid, 1'b0);
        step(1'b1, 32'hB0, 1'b0, 32'h0, 1'b0);
        check_eq("redir_out_pc", out_pc, 32'h100);
        check_eq("redir_out_inst", out_inst, 32'hB0);
        check_eq("redir_next_addr", inst_addr, 32'h104);

        // Redirect coincident with a response and a pop
        step(1'b1, 32'hCC, 1'b1, 32'h200, 1'b1);
        check_eq("coinc_empty", out_valid, 1'b0);
        check_eq("coinc_req", inst_req, 1'b1);
        check_eq("coinc_addr", inst_addr, 32'h200);
        step(1'b1, 32'hD0, 1'b0, 32'h0, 1'b0);
        check_eq("coinc_out_pc", out_pc, 32'h200);
        check_eq("coinc_out_inst", out_inst, 32'hD0);

        // Address wrap at the top of the address space
        step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        check_eq("wrap_hold", inst_addr, 32'h204);
        step(1'b1, 32'hDEAD, 1'b0, 32'h0, 1'b0);
        check_eq("wrap_addr", inst_addr, 32'hFFFF_FFFC);
        step(1'b1, 32'hE0, 1'b0, 32'h0, 1'b0);
        check_eq("wrap_next_addr", inst_addr, 32'h0);
        check_eq("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        idle(1'b1);
        step(1'b1, 32'hE1, 1'b0, 32'h0, 1'b1);
        check_eq("post_wrap_addr", inst_addr, 32'h4);
`ifdef FETCH_QUEUE_BYPASS_EN
        check_eq("bypass_consumed", out_valid, 1'b0);
`else
        check_eq("resp_to_out", out_valid, 1'b1);
        check_eq("resp_to_out_pc", out_pc, 32'h0);
        check_eq("resp_to_out_inst", out_inst, 32'hE1);
`endif

        // Randomized traffic with a mid-run asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst = 1'b0;
                model_reset();
                for (int j = 0; j < 3; j++) rand_step();
                rst = 1'b1;
            end
            v   = m_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            r   = ($urandom_range(0, 15) == 0);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(v, $urandom, r, rp, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
